rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Writer-side front end for the 3-port register file. It merges two result sources into the file's single write port (wr/addr3/data3). The sources are the in-order pipeline writeback and the long-latency multiply/divide unit. Multi-cycle results are buffered in a small FIFO, pending destinations are tracked in a scoreboard for the hazard unit, and a pipeline hold is requested when buffered results starve.

Parameters:
DEPTH, 2, multiply/divide result FIFO entries (power of 2, >=2)
HOLD_THRESH, 3, consecutive cycles a FIFO head may wait before wb_hold asserts

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
wb_valid  input  1  pipeline writeback valid this cycle (cannot be stalled)
wb_addr  input  5  pipeline destination register
wb_data  input  32  pipeline result
md_valid  input  1  mult/div result offered
md_addr  input  5  mult/div destination register
md_data  input  32  mult/div result
md_ready  output  1  FIFO can accept (not full); transfer = md_valid & md_ready
iss_valid  input  1  mult/div op issued with destination iss_addr
iss_addr  input  5  destination of issued mult/div op
q_addr1  input  5  scoreboard query (decode rs)
q_addr2  input  5  scoreboard query (decode rt)
q_busy1  output  1  q_addr1 has a pending mult/div write (combinational)
q_busy2  output  1  q_addr2 has a pending mult/div write (combinational)
wb_hold  output  1  request pipeline to leave next writeback slot empty
rf_wr  output  1  register file write enable (to wr)
rf_addr  output  5  register file write address (to addr3)
rf_data  output  32  register file write data (to data3)

Behaviour:
- Reset (reset=0, async): FIFO empty, md_ready=1, scoreboard all clear, wait counter 0, wb_hold=0, rf_wr=0, rf_addr=0, rf_data=0. Reset mid-operation discards buffered results and pending bits.
- Write port outputs are registered; latency is 1 cycle from the accepted source to rf_wr/rf_addr/rf_data.
- Slot selection, each cycle:
  - wb_valid=1 and wb_addr!=0: pipeline wins; rf_wr<=1, rf_addr<=wb_addr, rf_data<=wb_data.
  - Otherwise, FIFO non-empty: pop head; rf_wr<=1 with the head's addr/data.
  - Otherwise: rf_wr<=0; rf_addr/rf_data hold their previous values.
- Writes to $0 are never issued. wb_addr=0 counts as an empty slot. An md entry with addr 0 is accepted and popped, but rf_wr<=0.
- FIFO: push on md_valid & md_ready. Pop and push in the same cycle is allowed. md_ready = ~full. Since md_ready is registered from occupancy, a full FIFO with a same-cycle pop still shows md_ready=0. Pointers wrap modulo DEPTH; no overflow or underflow under any input.
- Wait counter: increments each cycle the FIFO is non-empty and no pop occurs; resets to 0 on any pop or when the FIFO is empty; saturates at HOLD_THRESH.
- wb_hold: registered, =1 while the counter equals HOLD_THRESH. The pipeline must present wb_valid=0 the next cycle. The pop then clears the counter and wb_hold drops in the following cycle. If wb_valid=1 arrives despite hold, the pipeline still wins (no data loss) and hold stays asserted.
- Scoreboard: 31 bits (regs 1..31).
  - iss_valid & iss_addr!=0 sets pending[iss_addr].
  - An md write reaching the register file (rf_wr cycle sourced from the FIFO) clears pending[addr].
  - Set and clear of the same addr in the same cycle: set wins.
  - Pipeline writes never clear pending bits.
- q_busyN = pending[q_addrN] & (q_addrN!=0), combinational from registered state. A cleared bit is seen in the same cycle the register file captures the data.
- No reordering: FIFO results reach the register file in arrival order.

Test Plan:
- Reset, then wb_valid=1, wb_addr=8, wb_data=32'h1234_5678 -> next cycle rf_wr=1, rf_addr=8, rf_data=32'h1234_5678; all reset values verified beforehand, including md_ready=1.
- iss_valid addr=9; later md result addr=9, data=32'hDEAD_BEEF with wb_valid=0 -> q_busy1 (q_addr1=9) high until write; rf_wr to 9 one cycle after pop; q_busy1 low from then.
- Same cycle: wb_valid addr=3 and md_valid addr=4 -> reg 3 written first, reg 4 written the next free cycle; ordering and data exact.
- wb_valid held 1 with FIFO holding 1 entry -> after 3 waiting cycles wb_hold=1; bench drops wb_valid; entry written; wb_hold=0 the following cycle.
- Fill FIFO (2 pushes, wb busy) -> md_ready=0; third md_valid is not taken; after one pop, md_ready=1 and the third result is written last; pointer wrap checked over 5+ pushes.
- Edge cases: wb_addr=0, md addr=0, iss_addr=0 -> never rf_wr to $0; scoreboard unchanged. Async reset asserted with a full FIFO -> outputs cleared immediately, no stale writes after release.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges pipeline writeback and buffered mult/div results onto the single register-file write port
//   clk, reset (async, active-low)
//   wb_valid/wb_addr/wb_data : pipeline writeback, always wins the slot, never stalled
//   md_valid/md_addr/md_data/md_ready : mult/div result handshake into the FIFO
//   iss_valid/iss_addr : mult/div issue, marks destination pending
//   q_addr1/q_addr2 -> q_busy1/q_busy2 : scoreboard queries for the hazard unit
//   wb_hold : asks the pipeline to leave the next writeback slot empty
//   rf_wr/rf_addr/rf_data : registered write port to the register file
module rf_write_arbiter #(
    parameter int DEPTH       = 2,
    parameter int HOLD_THRESH = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        q_busy1,
    output logic        q_busy2,
    output logic        wb_hold,
    output logic        rf_wr,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(HOLD_THRESH + 1);

    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   pending, pending_nxt;
    logic          wb_sel, empty, push, pop;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    assign wb_sel    = wb_valid && wb_addr != 5'd0;
    assign empty     = count == '0;
    assign md_ready  = count != (AW+1)'(DEPTH);
    assign push      = md_valid && md_ready;
    assign pop       = !empty && !wb_sel;
    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];
    assign wb_hold   = wait_cnt == CW'(HOLD_THRESH);
    // bit 0 is never set, so $0 always reads as not busy
    assign q_busy1   = pending[q_addr1] && q_addr1 != 5'd0;
    assign q_busy2   = pending[q_addr2] && q_addr2 != 5'd0;

    // clear on the pop that drives rf_wr, then set so a same-cycle reissue wins
    always_comb begin
        pending_nxt = pending;
        if (pop && head_addr != 5'd0) pending_nxt[head_addr] = 1'b0;
        if (iss_valid && iss_addr != 5'd0) pending_nxt[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= md_addr;
            mem_data[wr_ptr] <= md_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
            pending  <= '0;
            rf_wr    <= 1'b0;
            rf_addr  <= '0;
            rf_data  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            wait_cnt <= (empty || pop) ? '0 : wb_hold ? wait_cnt : wait_cnt + CW'(1);
            pending  <= pending_nxt;
            if (wb_sel) begin
                rf_wr   <= 1'b1;
                rf_addr <= wb_addr;
                rf_data <= wb_data;
            end else if (pop && head_addr != 5'd0) begin
                rf_wr   <= 1'b1;
                rf_addr <= head_addr;
                rf_data <= head_data;
            end else begin
                rf_wr <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed vectors with hand-computed expectations for rf_write_arbiter
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_addr = '0;
    logic [31:0] md_data = '0;
    logic        md_ready;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic [4:0]  q_addr1 = '0;
    logic [4:0]  q_addr2 = '0;
    logic        q_busy1, q_busy2, wb_hold, rf_wr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    int n_vec = 0;
    int n_err = 0;

    rf_write_arbiter #(.DEPTH(2), .HOLD_THRESH(3)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .wb_hold(wb_hold), .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_wr"}, 32'(rf_wr), 32'd1);
        chk({tag, "_addr"}, 32'(rf_addr), 32'(a));
        chk({tag, "_data"}, rf_data, d);
    endtask

    task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb_valid = v; wb_addr = a; wb_data = d;
    endtask

    task automatic md(input logic v, input logic [4:0] a, input logic [31:0] d);
        md_valid = v; md_addr = a; md_data = d;
    endtask

    initial begin
        step(); step();
        chk("rst_wr", 32'(rf_wr), 32'd0);
        chk("rst_addr", 32'(rf_addr), 32'd0);
        chk("rst_data", rf_data, 32'd0);
        chk("rst_ready", 32'(md_ready), 32'd1);
        chk("rst_hold", 32'(wb_hold), 32'd0);
        reset = 1'b1;
        step();
        chk("idle_wr", 32'(rf_wr), 32'd0);

        wb(1, 5'd8, 32'h1234_5678);
        step();
        wr("wb8", 5'd8, 32'h1234_5678);
        wb(0, 5'd0, 32'h0);
        step();
        chk("empty_wr", 32'(rf_wr), 32'd0);
        chk("empty_addr_held", 32'(rf_addr), 32'd8);

        iss_valid = 1'b1; iss_addr = 5'd9; q_addr1 = 5'd9;
        step();
        iss_valid = 1'b0;
        chk("sb9_set", 32'(q_busy1), 32'd1);
        step();
        chk("sb9_held", 32'(q_busy1), 32'd1);
        md(1, 5'd9, 32'hDEAD_BEEF);
        step();
        md(0, 5'd0, 32'h0);
        chk("md9_push_wr", 32'(rf_wr), 32'd0);
        chk("sb9_pushed", 32'(q_busy1), 32'd1);
        step();
        wr("md9", 5'd9, 32'hDEAD_BEEF);
        chk("sb9_clear", 32'(q_busy1), 32'd0);
        step();
        chk("md9_after_wr", 32'(rf_wr), 32'd0);
        chk("sb9_stays_clear", 32'(q_busy1), 32'd0);

        wb(1, 5'd3, 32'h0000_0033);
        md(1, 5'd4, 32'h0000_0044);
        step();
        wb(0, 5'd0, 32'h0);
        md(0, 5'd0, 32'h0);
        wr("order_wb3", 5'd3, 32'h33);
        step();
        wr("order_md4", 5'd4, 32'h44);
        step();
        chk("order_done", 32'(rf_wr), 32'd0);

        wb(1, 5'd10, 32'hA0);
        md(1, 5'd5, 32'h55);
        step();
        md(0, 5'd0, 32'h0);
        chk("hold_c1", 32'(wb_hold), 32'd0);
        wb(1, 5'd11, 32'hA1);
        step();
        chk("hold_c2", 32'(wb_hold), 32'd0);
        wb(1, 5'd12, 32'hA2);
        step();
        chk("hold_c3", 32'(wb_hold), 32'd0);
        wb(1, 5'd13, 32'hA3);
        step();
        chk("hold_set", 32'(wb_hold), 32'd1);
        wr("hold_wb13", 5'd13, 32'hA3);
        wb(1, 5'd14, 32'hA4);
        step();
        chk("hold_ignored_stays", 32'(wb_hold), 32'd1);
        wr("hold_wb_wins", 5'd14, 32'hA4);
        wb(0, 5'd0, 32'h0);
        step();
        wr("hold_pop5", 5'd5, 32'h55);
        chk("hold_drop", 32'(wb_hold), 32'd0);

        wb(1, 5'd20, 32'hB0);
        md(1, 5'd17, 32'h1);
        step();
        md(1, 5'd18, 32'h2);
        step();
        chk("full_ready", 32'(md_ready), 32'd0);
        md(1, 5'd19, 32'h3);
        step();
        chk("full_ready_still", 32'(md_ready), 32'd0);
        chk("full_no_hold", 32'(wb_hold), 32'd0);
        wb(0, 5'd0, 32'h0);
        step();
        wr("full_pop17", 5'd17, 32'h1);
        chk("after_pop_ready", 32'(md_ready), 32'd1);
        step();
        md(0, 5'd0, 32'h0);
        wr("full_pop18", 5'd18, 32'h2);
        step();
        wr("full_pop19_last", 5'd19, 32'h3);
        step();
        chk("full_drained", 32'(rf_wr), 32'd0);
        chk("full_drained_ready", 32'(md_ready), 32'd1);

        iss_valid = 1'b1; iss_addr = 5'd7; q_addr2 = 5'd7;
        step();
        iss_valid = 1'b0;
        chk("sb7_set", 32'(q_busy2), 32'd1);
        wb(1, 5'd0, 32'hFF);
        md(1, 5'd0, 32'hEE);
        iss_valid = 1'b1; iss_addr = 5'd0; q_addr1 = 5'd0;
        step();
        wb(0, 5'd0, 32'h0);
        md(0, 5'd0, 32'h0);
        iss_valid = 1'b0;
        chk("zero_wb_wr", 32'(rf_wr), 32'd0);
        chk("zero_q_busy", 32'(q_busy1), 32'd0);
        step();
        chk("zero_md_wr", 32'(rf_wr), 32'd0);
        chk("zero_addr_held", 32'(rf_addr), 32'd19);
        chk("zero_sb7_kept", 32'(q_busy2), 32'd1);
        chk("zero_fifo_empty", 32'(md_ready), 32'd1);
        wb(1, 5'd7, 32'h77);
        step();
        wb(0, 5'd0, 32'h0);
        wr("wb7", 5'd7, 32'h77);
        chk("wb7_no_clear", 32'(q_busy2), 32'd1);
        md(1, 5'd7, 32'h7);
        step();
        md(0, 5'd0, 32'h0);
        iss_valid = 1'b1; iss_addr = 5'd7;
        step();
        iss_valid = 1'b0;
        wr("md7", 5'd7, 32'h7);
        chk("set_wins", 32'(q_busy2), 32'd1);

        wb(1, 5'd21, 32'hC0);
        md(1, 5'd14, 32'hE);
        step();
        md(1, 5'd15, 32'hF);
        step();
        md(0, 5'd0, 32'h0);
        chk("pre_rst_full", 32'(md_ready), 32'd0);
        chk("pre_rst_wr", 32'(rf_wr), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_wr", 32'(rf_wr), 32'd0);
        chk("arst_addr", 32'(rf_addr), 32'd0);
        chk("arst_ready", 32'(md_ready), 32'd1);
        chk("arst_sb", 32'(q_busy2), 32'd0);
        wb(0, 5'd0, 32'h0);
        #3;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_stale", 32'(rf_wr), 32'd0);
        end
        chk("post_rst_hold", 32'(wb_hold), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
